// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: FSM states, BCD time layout, digit limits.
// Latency: n/a; backpressure: n/a.
package stopwatch_pkg;

    localparam int DISP_W = 24;

    localparam logic [3:0] DIGIT_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    // Field order matches the display word {mm_t, mm_o, ss_t, ss_o, cc_t, cc_o}.
    typedef struct packed {
        logic [3:0] mm_t;
        logic [3:0] mm_o;
        logic [3:0] ss_t;
        logic [3:0] ss_o;
        logic [3:0] cc_t;
        logic [3:0] cc_o;
    } bcd_time_t;

    function automatic int tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: tick is combinational, high in the last cycle of each DIV-cycle period.
// Latency: tick in the DIV-th enabled cycle after clear; backpressure: none, holds count while en is low.
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clock_in,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/pause/lap/clear FSM, gated prescaler, mm:ss.cc BCD counter, display mux.
// Latency: button pulse to state change 1 cycle, tick to display 1 cycle; backpressure: none.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 100
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic              start_stop,
    input  logic              lap,
    input  logic              clear,
    output logic [DISP_W-1:0] disp_bcd,
    output logic              running,
    output logic              lap_active,
    output logic              overflow,
    output logic              tick_out
);

    localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);

    if ((CLK_HZ % TICK_HZ) != 0 || TICK_DIV < 2) begin : g_bad_div
        $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
    end

    state_t    state_q, state_d;
    bcd_time_t time_q, time_d;
    bcd_time_t lap_q, lap_d;
    logic      overflow_q, overflow_d;
    logic      tick_out_q;

    logic      counting;
    logic      enter_idle;
    logic      tick;
    bcd_time_t time_inc;
    logic      time_wrap;

    assign counting   = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign enter_idle = (state_d == ST_IDLE);

    tick_prescaler #(
        .DIV(TICK_DIV)
    ) u_prescaler (
        .clock_in(clock_in),
        .reset_n (reset_n),
        .en      (counting),
        .clr     (enter_idle),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_stop) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_stop)  state_d = ST_PAUSE;
                else if (lap)    state_d = ST_LAP;
            end
            ST_LAP: begin
                if (start_stop)  state_d = ST_PAUSE;
                else if (lap)    state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (start_stop)  state_d = ST_RUN;
                else if (clear)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Ripple carry through the six BCD digits; wrap flags 59:59.99 -> 00:00.00.
    always_comb begin
        time_inc  = time_q;
        time_wrap = 1'b0;
        if (time_q.cc_o != DIGIT_MAX) begin
            time_inc.cc_o = time_q.cc_o + 4'd1;
        end else begin
            time_inc.cc_o = 4'd0;
            if (time_q.cc_t != DIGIT_MAX) begin
                time_inc.cc_t = time_q.cc_t + 4'd1;
            end else begin
                time_inc.cc_t = 4'd0;
                if (time_q.ss_o != DIGIT_MAX) begin
                    time_inc.ss_o = time_q.ss_o + 4'd1;
                end else begin
                    time_inc.ss_o = 4'd0;
                    if (time_q.ss_t != TENS_MAX) begin
                        time_inc.ss_t = time_q.ss_t + 4'd1;
                    end else begin
                        time_inc.ss_t = 4'd0;
                        if (time_q.mm_o != DIGIT_MAX) begin
                            time_inc.mm_o = time_q.mm_o + 4'd1;
                        end else begin
                            time_inc.mm_o = 4'd0;
                            if (time_q.mm_t != TENS_MAX) begin
                                time_inc.mm_t = time_q.mm_t + 4'd1;
                            end else begin
                                time_inc.mm_t = 4'd0;
                                time_wrap     = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        time_d     = time_q;
        overflow_d = overflow_q;
        lap_d      = lap_q;
        if (enter_idle) begin
            time_d     = '0;
            overflow_d = 1'b0;
        end else if (tick) begin
            time_d = time_inc;
            if (time_wrap) overflow_d = 1'b1;
        end
        // Capture reads time_q, so a coincident tick is not included.
        if (state_q == ST_RUN && lap && !start_stop) begin
            lap_d = time_q;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            time_q     <= '0;
            lap_q      <= '0;
            overflow_q <= 1'b0;
            tick_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            lap_q      <= lap_d;
            overflow_q <= overflow_d;
            tick_out_q <= tick;
        end
    end

    assign disp_bcd   = (state_q == ST_LAP) ? lap_q : time_q;
    assign running    = counting;
    assign lap_active = (state_q == ST_LAP);
    assign overflow   = overflow_q;
    assign tick_out   = tick_out_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at CLK_HZ=1000, TICK_HZ=100 (ten clocks per centisecond).
module tb_stopwatch_ctrl;

    logic        clock_in   = 1'b0;
    logic        reset_n    = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap        = 1'b0;
    logic        clear      = 1'b0;
    logic [23:0] disp_bcd;
    logic        running;
    logic        lap_active;
    logic        overflow;
    logic        tick_out;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock_in = ~clock_in;

    stopwatch_ctrl #(
        .CLK_HZ (1000),
        .TICK_HZ(100)
    ) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .start_stop(start_stop),
        .lap       (lap),
        .clear     (clear),
        .disp_bcd  (disp_bcd),
        .running   (running),
        .lap_active(lap_active),
        .overflow  (overflow),
        .tick_out  (tick_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock_in);
        #1;
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        step(1);
        lap = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        logic seen_tick;

        // 1: reset and idle
        #3;
        check_eq("rst_disp", disp_bcd, 32'h000000);
        check_eq("rst_running", running, 0);
        check_eq("rst_lap_active", lap_active, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_tick_out", tick_out, 0);
        step(2);
        reset_n = 1'b1;
        seen_tick = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            seen_tick = seen_tick | tick_out;
        end
        check_eq("idle_no_tick", seen_tick, 0);
        check_eq("idle_disp", disp_bcd, 32'h000000);
        check_eq("idle_running", running, 0);

        // 2: start at cycle 0
        pulse_start();
        check_eq("start_running_c1", running, 1);
        seen_tick = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            step(1);
            seen_tick = seen_tick | tick_out;
        end
        check_eq("no_tick_before_c11", seen_tick, 0);
        check_eq("disp_c10", disp_bcd, 32'h000000);
        step(1);
        check_eq("first_tick_c11", tick_out, 1);
        check_eq("disp_c11", disp_bcd, 32'h000001);
        step(1000);
        check_eq("disp_c1011", disp_bcd, 32'h000101);

        // 3: pause with prescaler at 4, resume, start+clear, clear
        step(3);
        pulse_start();
        check_eq("pause_running", running, 0);
        check_eq("pause_disp", disp_bcd, 32'h000101);
        step(100);
        check_eq("pause_hold_disp", disp_bcd, 32'h000101);
        pulse_start();
        check_eq("resume_running", running, 1);
        step(5);
        check_eq("resume_no_tick_early", tick_out, 0);
        check_eq("resume_disp_before", disp_bcd, 32'h000101);
        step(1);
        check_eq("resume_tick_after_6", tick_out, 1);
        check_eq("resume_disp_after", disp_bcd, 32'h000102);
        pulse_start();
        start_stop = 1'b1;
        clear      = 1'b1;
        step(1);
        start_stop = 1'b0;
        clear      = 1'b0;
        check_eq("start_clear_running", running, 1);
        check_eq("start_clear_disp", disp_bcd, 32'h000102);
        pulse_start();
        pulse_clear();
        check_eq("clear_disp", disp_bcd, 32'h000000);
        check_eq("clear_running", running, 0);

        // 4: lap freeze at 00:03.47
        pulse_start();
        step(3474);
        check_eq("live_before_lap", disp_bcd, 32'h000347);
        pulse_lap();
        check_eq("lap_active_on", lap_active, 1);
        check_eq("lap_disp_frozen", disp_bcd, 32'h000347);
        step(500);
        check_eq("lap_disp_50ticks", disp_bcd, 32'h000347);
        check_eq("lap_still_running", running, 1);
        pulse_lap();
        check_eq("lap_release", lap_active, 0);
        check_eq("lap_release_live", disp_bcd, 32'h000397);
        step(3);
        pulse_lap();
        check_eq("lap_on_tick_pre_inc", disp_bcd, 32'h000397);
        pulse_lap();
        check_eq("live_after_tick_lap", disp_bcd, 32'h000398);

        // 5: wrap from 59:59.98
        pulse_start();
        force dut.time_q = 24'h595998;
        step(1);
        release dut.time_q;
        check_eq("preset_disp", disp_bcd, 32'h595998);
        pulse_start();
        step(8);
        check_eq("wrap_disp_595999", disp_bcd, 32'h595999);
        check_eq("wrap_ovf_before", overflow, 0);
        step(10);
        check_eq("wrap_disp_zero", disp_bcd, 32'h000000);
        check_eq("wrap_ovf_set", overflow, 1);
        check_eq("wrap_tick_out", tick_out, 1);
        pulse_start();
        check_eq("ovf_sticky_pause", overflow, 1);
        check_eq("ovf_pause_running", running, 0);
        pulse_clear();
        check_eq("ovf_cleared_idle", overflow, 0);

        // 6: async reset mid-count
        pulse_start();
        step(25);
        check_eq("pre_reset_disp", disp_bcd, 32'h000002);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_disp", disp_bcd, 32'h000000);
        check_eq("async_rst_running", running, 0);
        check_eq("async_rst_lap_active", lap_active, 0);
        check_eq("async_rst_overflow", overflow, 0);
        check_eq("async_rst_tick_out", tick_out, 0);
        step(2);
        reset_n = 1'b1;
        step(20);
        check_eq("post_rst_idle_disp", disp_bcd, 32'h000000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Top-level sequencer for the stopwatch.
- Owns the run/pause/lap/clear state machine and gates a clock-enable prescaler, replacing the free-running divide-by-N blinker style.
- Maintains the mm:ss.cc time in BCD and drives the display digits and a tick pulse.
- Sits between the debounced button pulses and the 7-segment display mux.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz (centiseconds). TICK_DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2; elaboration error otherwise.

Ports:
- clock_in  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset. Assertion is asynchronous; release is assumed synchronized upstream.
- start_stop  input  1  single-cycle pulse, already debounced and synchronized.
- lap  input  1  single-cycle pulse, debounced and synchronized.
- clear  input  1  single-cycle pulse, debounced and synchronized.
- disp_bcd  output  24  displayed time {mm_t, mm_o, ss_t, ss_o, cc_t, cc_o}, 4 bits each.
- running  output  1  high in RUN or LAP.
- lap_active  output  1  high in LAP (display frozen).
- overflow  output  1  sticky wrap flag.
- tick_out  output  1  one-cycle pulse per count increment.

Behaviour:
- Reset (reset_n=0), asynchronous:
  - state=IDLE, prescaler=0, time=00:00.00, lap register=0.
  - disp_bcd=24'h000000; running=0, lap_active=0, overflow=0, tick_out=0.
- States (encoding in package): IDLE, RUN, PAUSE, LAP.
- Transitions are evaluated once per cycle with priority start_stop > lap > clear. Any pulse not listed is ignored.
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE; lap -> LAP, capturing the live time into the lap register.
  - LAP: start_stop -> PAUSE (freeze released); lap -> RUN (freeze released). Time keeps counting throughout LAP.
  - PAUSE: start_stop -> RUN; clear -> IDLE. Entering IDLE zeroes time, the prescaler and overflow.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN or LAP. Holds its value in PAUSE, so the sub-tick fraction is preserved across a pause. Zeroed in IDLE.
  - tick = counting && prescaler==TICK_DIV-1. On tick the prescaler wraps to 0.
  - tick_out is registered: high the cycle after the tick.
- Latency:
  - A start_stop pulse in cycle N gives running=1 in N+1; the prescaler counts from N+1.
  - The first tick occurs in cycle N+TICK_DIV; the incremented time is visible in N+TICK_DIV+1.
- Time arithmetic on tick, per-digit BCD:
  - cc_o 0-9 carries to cc_t 0-9 (cc 00-99), which carries to ss 00-59, which carries to mm 00-59.
  - 59:59.99 + tick -> 00:00.00 and sets overflow=1. overflow stays high until reset or entry to IDLE.
  - No digit ever holds a value greater than 9 (tens of ss/mm never greater than 5).
- Display: disp_bcd = lap register while in LAP, otherwise the live time. It is a pure mux of registers, so there is no added latency.
- Simultaneous events:
  - A lap capture coinciding with a tick captures the pre-increment value.
  - A start_stop coinciding with a tick in RUN: the tick's increment is still applied, then the state goes to PAUSE.
  - start_stop and clear together in PAUSE -> RUN; clear is dropped.
- Reset mid-count: asynchronous return to reset values within the same cycle; no partial state survives.

Decomposition:
- stopwatch_pkg holds:
  - state encodings (2-bit);
  - digit limits (9, 5);
  - the tick divider function TICK_DIV = CLK_HZ/TICK_HZ;
  - the 24-bit display width constant.
- Sub-module tick_prescaler:
  - parameter DIV;
  - ports clock_in, reset_n, en, sync clear, tick out.
- The BCD cascade stays inline in stopwatch_ctrl.

Test Plan (CLK_HZ=1000, TICK_HZ=100 => TICK_DIV=10):
1. Reset then idle 50 cycles -> disp_bcd=000000, running=0, tick_out never high.
2. start_stop at cycle 0 -> running=1 at cycle 1; first tick_out at cycle 11; disp_bcd=000001 at cycle 11. After 1000 further cycles disp_bcd=000101.
3. RUN 4 cycles into a tick period, start_stop, wait 100 cycles, start_stop -> disp_bcd unchanged across the pause; next tick lands 6 counting cycles after resume. Then clear with both start_stop and clear high together -> RUN (clear ignored). Pause again, clear -> disp_bcd=000000, running=0.
4. At live 00:03.47 pulse lap -> lap_active=1, disp_bcd holds 000347 for 50 ticks. Pulse lap again -> disp_bcd shows live 000397.
5. Force time to 59:59.98 (via run), 2 ticks -> 595999, then 000000 with overflow=1. overflow persists through PAUSE and clears on clear to IDLE.
6. Assert reset_n low mid-count between clock edges -> all outputs zero immediately, before the next clock_in edge.
